// File: rtl/pbqm_pkg.sv
// pbqm_pkg: shared definitions for the queue-monitor slice.
// Holds default parameter values, the divider-controller state encoding
// and the numerator-width helper used to size the divider.
package pbqm_pkg;

  localparam int CNT_W_DEF  = 3;
  localparam int TCNT_W_DEF = 2;
  localparam int SVC_T_DEF  = 3;
  localparam int WT_W_DEF   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bits needed for the largest numerator SVC_T*(Pmax + Tmax - 1).
  function automatic int num_width(input int svc_t, input int cnt_w, input int tcnt_w);
    int v;
    v = svc_t * ((1 << cnt_w) + (1 << tcnt_w) - 3);
    return (v < 3) ? 2 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/pbqm_div.sv
// pbqm_div: restoring unsigned divider, one quotient bit per clock.
// Ports: start_i loads num_i/den_i; busy_o high for NUM_W cycles;
// done_o flags the cycle whose rising edge retires the last bit; quo_o result.
module pbqm_div #(
  parameter int NUM_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [NUM_W-1:0] den_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quo_o
);
  localparam int CW = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] rem_q, quo_q, den_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [NUM_W:0]   rem_sh, rem_sub;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // the top bit of the difference is the borrow.
  assign rem_sh  = {rem_q, quo_q[NUM_W-1]};
  assign rem_sub = rem_sh - {1'b0, den_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= num_i;
      den_q  <= den_i;
      cnt_q  <= CW'(NUM_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (!rem_sub[NUM_W]) begin
        rem_q <= rem_sub[NUM_W-1:0];
        quo_q <= {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[NUM_W-1:0];
        quo_q <= {quo_q[NUM_W-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign quo_o  = quo_q;

endmodule

// File: rtl/pbqm.sv
// pbqm: bank-queue monitor -- counts customers from two photocells and
// estimates waiting time with a sequential divider.
// Ports: clk/rst, backPC/frontPC photocells, Tcount tellers, clr_err;
// Pcount/full/empty, Wtime/wvalid, sticky ovf/udf, closed.
module pbqm
  import pbqm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TCNT_W = TCNT_W_DEF,
  parameter int SVC_T  = SVC_T_DEF,
  parameter int WT_W   = WT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              backPC,
  input  logic              frontPC,
  input  logic [TCNT_W-1:0] Tcount,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  Pcount,
  output logic              full,
  output logic              empty,
  output logic [WT_W-1:0]   Wtime,
  output logic              wvalid,
  output logic              ovf,
  output logic              udf,
  output logic              closed
);
  localparam int NUM_W = num_width(SVC_T, CNT_W, TCNT_W);
  localparam logic [CNT_W-1:0] P_MAX  = '1;
  localparam logic [WT_W-1:0]  WT_ONES = '1;

  logic              back_s1_q, back_s2_q, back_h_q;
  logic              front_s1_q, front_s2_q, front_h_q;
  logic              ent, ext;
  logic [CNT_W-1:0]  pcount_q, pcount_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic [TCNT_W-1:0] tq_q;
  logic              closed_q;

  state_t            state_q;
  logic [CNT_W-1:0]  snap_p_q;
  logic [TCNT_W-1:0] snap_t_q;
  logic [WT_W-1:0]   wtime_q, wtime_tgt;
  logic              wvalid_q;
  logic              chg, bypass, div_start, div_busy, div_done;
  logic [NUM_W-1:0]  div_num, div_den, div_quo;

  // Falls seen on the synchronised photocells (history resets high so
  // reset release never looks like an entry/exit).
  assign ent = back_h_q & ~back_s2_q;
  assign ext = front_h_q & ~front_s2_q;

  always_comb begin
    pcount_d = pcount_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    // A new error is applied after the clear so it wins.
    if (ent && !ext) begin
      if (pcount_q == P_MAX) ovf_d = 1'b1;
      else                   pcount_d = pcount_q + CNT_W'(1);
    end else if (ext && !ent) begin
      if (pcount_q == '0) udf_d = 1'b1;
      else                pcount_d = pcount_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      back_s1_q  <= 1'b1;
      back_s2_q  <= 1'b1;
      back_h_q   <= 1'b1;
      front_s1_q <= 1'b1;
      front_s2_q <= 1'b1;
      front_h_q  <= 1'b1;
      pcount_q   <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      tq_q       <= '0;
      closed_q   <= 1'b1;
    end else begin
      back_s1_q  <= backPC;
      back_s2_q  <= back_s1_q;
      back_h_q   <= back_s2_q;
      front_s1_q <= frontPC;
      front_s2_q <= front_s1_q;
      front_h_q  <= front_s2_q;
      pcount_q   <= pcount_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      tq_q       <= Tcount;
      closed_q   <= (Tcount == '0);
    end
  end

  // Divider operands, computed from live values and sampled in LOAD.
  assign chg       = (pcount_q != snap_p_q) || (tq_q != snap_t_q);
  assign bypass    = (pcount_q == '0) || (tq_q == '0);
  assign div_start = (state_q == ST_LOAD) && !bypass;
  assign div_num   = NUM_W'(SVC_T) * (NUM_W'(pcount_q) + NUM_W'(tq_q) - NUM_W'(1));
  assign div_den   = NUM_W'(tq_q);

  pbqm_div #(.NUM_W(NUM_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (div_den),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

  // Result selection uses the snapshot, so bypass cases ignore the divider.
  always_comb begin
    wtime_tgt = WT_ONES;
    if (snap_p_q == '0)                  wtime_tgt = '0;
    else if (snap_t_q == '0)             wtime_tgt = WT_ONES;
    else if ((div_quo >> WT_W) != '0)    wtime_tgt = WT_ONES;
    else                                 wtime_tgt = WT_W'(div_quo);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      snap_p_q <= '0;
      snap_t_q <= '0;
      wtime_q  <= '0;
      wvalid_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (chg) begin
            state_q  <= ST_LOAD;
            wvalid_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          snap_p_q <= pcount_q;
          snap_t_q <= tq_q;
          state_q  <= bypass ? ST_DONE : ST_DIV;
        end
        ST_DIV: begin
          // Restart on operand change; an idle divider here also restarts.
          if (chg || !div_busy) state_q <= ST_LOAD;
          else if (div_done)    state_q <= ST_DONE;
        end
        default: begin
          // Operands moving on the publishing edge would make the result stale.
          if (chg) begin
            state_q <= ST_LOAD;
          end else begin
            wtime_q  <= wtime_tgt;
            wvalid_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign Pcount = pcount_q;
  assign full   = (pcount_q == P_MAX);
  assign empty  = (pcount_q == '0);
  assign Wtime  = wtime_q;
  assign wvalid = wvalid_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;
  assign closed = closed_q;

endmodule
